// File: rtl/text_pixel_gen.sv
// Character-cell text renderer: fetches char/attribute from text RAM, glyph rows
// from font ROM, and serialises one 8-pixel cell every 8 dot clocks.
module text_pixel_gen #(
  parameter int COLS = 80,
  parameter int ROWS = 30
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        frameStart,
  input  logic        lineStart,
  output logic [11:0] textAddr,
  input  logic [15:0] textData,
  output logic [11:0] fontAddr,
  input  logic [7:0]  fontData,
  output logic        fgRed,
  output logic        fgGreen,
  output logic        fgBlue,
  output logic        fgIntense,
  output logic        bgRed,
  output logic        bgGreen,
  output logic        bgBlue,
  output logic        bgIntense,
  output logic        pixel
);

  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [11:0]      COLS12   = 12'(COLS);

  logic [2:0]       phase_q, phase_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [3:0]       scan_q, scan_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [4:0]       blink_q, blink_d;
  logic             fetch_q, fetch_d;
  // fv: the cell now in the font stage came from this line; sv: same for the shifter
  logic             fv_q, fv_d;
  logic             sv_q, sv_d;
  logic [7:0]       sh_q, sh_d;
  logic [7:0]       pend_q, pend_d;
  logic [7:0]       attr_q, attr_d;
  logic [11:0]      taddr_q, taddr_d;
  logic [11:0]      faddr_q, faddr_d;
  // {pixel, fgR, fgG, fgB, fgI, bgR, bgG, bgB}
  logic [7:0]       out_q, out_d;
  logic             pix_c;

  assign pix_c = sh_q[7] & ~(attr_q[7] & blink_q[4]);

  always_comb begin
    phase_d = phase_q + 3'd1;
    col_d   = col_q;
    scan_d  = scan_q;
    row_d   = row_q;
    blink_d = blink_q;
    fetch_d = fetch_q;
    fv_d    = fv_q;
    sv_d    = sv_q;
    sh_d    = {sh_q[6:0], 1'b0};
    pend_d  = pend_q;
    attr_d  = attr_q;
    taddr_d = taddr_q;
    faddr_d = faddr_q;
    out_d   = '0;

    if (sv_q)
      out_d = {pix_c, attr_q[2], attr_q[1], attr_q[0], attr_q[3],
               attr_q[6], attr_q[5], attr_q[4]};

    if (phase_q == 3'd1) begin
      fv_d    = fetch_q;
      faddr_d = {textData[7:0], scan_q};
      pend_d  = textData[15:8];
    end

    if (phase_q == 3'd3) begin
      sv_d   = fv_q;
      sh_d   = fv_q ? fontData : 8'h00;
      attr_d = pend_q;
    end

    // Last address was issued a slot ago; the final cell still drains through the pipe.
    if (!lineStart && fetch_q && phase_q == 3'd7) begin
      if (col_q == COL_LAST) begin
        fetch_d = 1'b0;
        scan_d  = scan_q + 4'd1;
        if (scan_q == 4'hF)
          row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d   = col_q + 1'b1;
        taddr_d = 12'(row_q) * COLS12 + 12'(col_q + 1'b1);
      end
    end

    if (frameStart) begin
      row_d   = '0;
      scan_d  = 4'd0;
      blink_d = blink_q + 5'd1;
    end

    if (lineStart) begin
      fetch_d = 1'b1;
      col_d   = '0;
      phase_d = 3'd0;
      fv_d    = 1'b0;
      sv_d    = 1'b0;
      sh_d    = 8'h00;
      out_d   = '0;
      taddr_d = 12'(row_d) * COLS12;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      phase_q <= '0;
      col_q   <= '0;
      scan_q  <= '0;
      row_q   <= '0;
      blink_q <= '0;
      fetch_q <= 1'b0;
      fv_q    <= 1'b0;
      sv_q    <= 1'b0;
      sh_q    <= '0;
      pend_q  <= '0;
      attr_q  <= '0;
      taddr_q <= '0;
      faddr_q <= '0;
      out_q   <= '0;
    end else begin
      phase_q <= phase_d;
      col_q   <= col_d;
      scan_q  <= scan_d;
      row_q   <= row_d;
      blink_q <= blink_d;
      fetch_q <= fetch_d;
      fv_q    <= fv_d;
      sv_q    <= sv_d;
      sh_q    <= sh_d;
      pend_q  <= pend_d;
      attr_q  <= attr_d;
      taddr_q <= taddr_d;
      faddr_q <= faddr_d;
      out_q   <= out_d;
    end
  end

  assign textAddr  = taddr_q;
  assign fontAddr  = faddr_q;
  assign pixel     = out_q[7];
  assign fgRed     = out_q[6];
  assign fgGreen   = out_q[5];
  assign fgBlue    = out_q[4];
  assign fgIntense = out_q[3];
  assign bgRed     = out_q[2];
  assign bgGreen   = out_q[1];
  assign bgBlue    = out_q[0];
  assign bgIntense = 1'b0;

endmodule

// File: tb/tb_text_pixel_gen.sv
// Bench for text_pixel_gen: registered RAM/ROM models returning fixed words,
// per-cycle line timing checks, and a row/scanline/blink reference model.
module tb_text_pixel_gen;
  localparam int COLS = 80;
  localparam int ROWS = 2;
  localparam int LINE = 648;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        frameStart = 1'b0;
  logic        lineStart = 1'b0;
  logic [11:0] textAddr, fontAddr;
  logic [15:0] textData = '0;
  logic [7:0]  fontData = '0;
  logic        fgRed, fgGreen, fgBlue, fgIntense, bgRed, bgGreen, bgBlue, bgIntense, pixel;

  text_pixel_gen #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk(clk), .nrst(nrst), .frameStart(frameStart), .lineStart(lineStart),
    .textAddr(textAddr), .textData(textData), .fontAddr(fontAddr), .fontData(fontData),
    .fgRed(fgRed), .fgGreen(fgGreen), .fgBlue(fgBlue), .fgIntense(fgIntense),
    .bgRed(bgRed), .bgGreen(bgGreen), .bgBlue(bgBlue), .bgIntense(bgIntense),
    .pixel(pixel)
  );

  always #5 clk = ~clk;

  logic [15:0] ram_word  = 16'h1F41;
  logic [7:0]  font_byte = 8'h81;
  always @(posedge clk) begin
    textData <= ram_word;
    fontData <= font_byte;
  end

  wire [8:0] obs = {pixel, fgRed, fgGreen, fgBlue, fgIntense, bgRed, bgGreen, bgBlue, bgIntense};

  typedef struct { int cyc; logic [8:0] exp; } vec_t;
  vec_t tbl[10];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int exp_row = 0;
  int exp_scan = 0;
  logic [4:0] exp_blink = '0;

  task automatic tick();
    @(posedge clk);
    #2;
    cyc++;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic pulse_frame();
    frameStart = 1'b1;
    tick();
    frameStart = 1'b0;
    exp_row = 0; exp_scan = 0; exp_blink = exp_blink + 5'd1;
  endtask

  // One full line; checks row base, glyph scanline, and optional extras.
  task automatic full_line(input bit with_frame, input bit all_addr, input bit use_tbl,
                           input bit pix_chk);
    int base;
    int pix_bad;
    logic [7:0] ch;
    pix_bad = 0;
    ch = ram_word[7:0];
    if (with_frame) begin
      exp_row = 0; exp_scan = 0; exp_blink = exp_blink + 5'd1;
    end
    base = exp_row * COLS;
    frameStart = with_frame;
    lineStart = 1'b1;
    cyc = 0;
    tick();
    lineStart = 1'b0;
    frameStart = 1'b0;
    while (cyc < LINE) begin
      if (cyc == 1) check("line_base", {4'h0, textAddr}, 16'(base));
      if (cyc == 3) check("font_addr", {4'h0, fontAddr}, {4'h0, ch, 4'(exp_scan)});
      if (all_addr && cyc >= 1 && cyc <= 8*COLS-7 && ((cyc - 1) % 8) == 0)
        check("addr_seq", {4'h0, textAddr}, 16'(base + (cyc - 1) / 8));
      if (all_addr && cyc == 645) check("addr_hold", {4'h0, textAddr}, 16'(base + COLS - 1));
      if (use_tbl)
        for (int i = 0; i < 10; i++)
          if (tbl[i].cyc == cyc) check("pix_tbl", {7'h0, obs}, {7'h0, tbl[i].exp});
      if (pix_chk) begin
        if (cyc >= 6 && cyc <= 6 + 8*COLS - 1) begin
          if (pixel !== ~exp_blink[4]) pix_bad++;
        end else if (cyc == 5 || cyc == 6 + 8*COLS) begin
          if (pixel !== 1'b0) pix_bad++;
        end
      end
      tick();
    end
    if (pix_chk) check("blink_line", 16'(pix_bad), 16'h0);
    exp_scan++;
    if (exp_scan == 16) begin
      exp_scan = 0;
      exp_row = (exp_row + 1) % ROWS;
    end
  endtask

  initial begin : main
    int base;
    int bad;
    logic [8:0] on_v, off_v;
    on_v  = 9'b1_1111_0010;
    off_v = 9'b0_1111_0010;
    tbl[0] = '{5,   9'h000};
    tbl[1] = '{6,   on_v};
    tbl[2] = '{7,   off_v};
    tbl[3] = '{12,  off_v};
    tbl[4] = '{13,  on_v};
    tbl[5] = '{14,  on_v};
    tbl[6] = '{20,  off_v};
    tbl[7] = '{644, off_v};
    tbl[8] = '{645, on_v};
    tbl[9] = '{646, 9'h000};

    // Reset state
    repeat (3) tick();
    check("rst_out", {7'h0, obs}, 16'h0);
    check("rst_taddr", {4'h0, textAddr}, 16'h0);
    check("rst_faddr", {4'h0, fontAddr}, 16'h0);
    nrst = 1'b1;
    tick();

    pulse_frame();
    full_line(1'b0, 1'b0, 1'b1, 1'b0);
    full_line(1'b0, 1'b1, 1'b0, 1'b0);
    // Lines 2..32: row 1 begins at line 16, wraps back to row 0 at line 32
    for (int i = 2; i <= 32; i++) full_line(1'b0, 1'b0, 1'b0, 1'b0);

    // Coincident frame+line mid-frame must restart at scanline 0, not 1
    full_line(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 31; i++) full_line(1'b0, 1'b0, 1'b0, 1'b0);
    full_line(1'b1, 1'b0, 1'b0, 1'b0);

    // Blink: attr bit7 set, solid glyph
    ram_word = 16'h8F41;
    font_byte = 8'hFF;
    while (exp_blink != 5'd16) pulse_frame();
    full_line(1'b0, 1'b0, 1'b0, 1'b1);
    while (exp_blink != 5'd0) pulse_frame();
    full_line(1'b0, 1'b0, 1'b0, 1'b1);

    // Abort at cycle 100, reset at cycle 200
    ram_word = 16'h1F41;
    base = exp_row * COLS;
    lineStart = 1'b1;
    cyc = 0;
    tick();
    lineStart = 1'b0;
    while (cyc < 100) tick();
    check("pre_abort_pix", {15'h0, pixel}, 16'h1);
    lineStart = 1'b1;
    tick();
    lineStart = 1'b0;
    check("abort_base", {4'h0, textAddr}, 16'(base));
    bad = 0;
    while (cyc < 106) begin
      if (pixel !== 1'b0) bad++;
      tick();
    end
    check("abort_gap", 16'(bad), 16'h0);
    check("abort_resume", {7'h0, obs}, {7'h0, on_v});
    while (cyc < 200) tick();
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    check("midrst_out", {7'h0, obs}, 16'h0);
    check("midrst_taddr", {4'h0, textAddr}, 16'h0);
    bad = 0;
    while (cyc < 900) begin
      if (obs !== 9'h0) bad++;
      tick();
    end
    check("quiet_after_rst", 16'(bad), 16'h0);
    exp_row = 0; exp_scan = 0; exp_blink = '0;
    full_line(1'b0, 1'b0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/text_pixel_gen.md
TEXT_PIXEL_GEN -- requirements
Module: text_pixel_gen

Interface
REQ-001 SHALL have parameter COLS, default 80, characters per text row.
REQ-002 SHALL have parameter ROWS, default 30, text rows per frame.
REQ-003 SHALL have port clk  input  1  VGA dot clock, all logic on posedge.
REQ-004 SHALL have port nrst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port frameStart  input  1  one-cycle pulse once per frame, before the first visible line.
REQ-006 SHALL have port lineStart  input  1  one-cycle pulse per visible line, exactly 6 clocks before that line's first visible pixel.
REQ-007 SHALL have port textAddr  output  12  text RAM address (row*COLS+col).
REQ-008 SHALL have port textData  input  16  text RAM read data: [7:0] char code, [15:8] attribute; valid the cycle after textAddr is presented.
REQ-009 SHALL have port fontAddr  output  12  font ROM address {char[7:0], scanline[3:0]}.
REQ-010 SHALL have port fontData  input  8  font ROM row, bit7 = leftmost pixel; valid the cycle after fontAddr is presented.
REQ-011 SHALL have ports fgRed, fgGreen, fgBlue, fgIntense, bgRed, bgGreen, bgBlue, bgIntense  output  1 each  colours for the current pixel.
REQ-012 SHALL have port pixel  output  1  1 = foreground, 0 = background.

Function
REQ-013 SHALL keep counters: phase (3 bits, 0-7), col (0..COLS-1), scanline (4 bits, 0-15), row (0..ROWS-1), blink (5 bits), plus fetch-active flag.
REQ-014 lineStart in cycle 0 SHALL set fetch-active, col=0, phase=0; textAddr = row*COLS+col is registered and valid in cycle 1+8k for character k.
REQ-015 SHALL register fontAddr = {textData[7:0], scanline} and latch textData[15:8] into a pending-attribute register at the clock edge ending cycle 2+8k (fontAddr valid cycle 3+8k).
REQ-016 SHALL load an 8-bit shifter from fontData and move pending attribute to active attribute at the edge ending cycle 4+8k; shifter shifts left once per clock otherwise.
REQ-017 Outputs SHALL be registered from shifter bit7 and active attribute; character k pixels appear in cycles 6+8k .. 13+8k, i.e. line pixels at cycles 6..6+8*COLS-1 (6..645 default).
REQ-018 Attribute map: [0] blue, [1] green, [2] red, [3] intense for fg; [4] blue, [5] green, [6] red for bg; bgIntense always 0; [7] blink.
REQ-019 pixel SHALL equal shifter bit7, forced to 0 when attr[7]=1 and blink[4]=1.
REQ-020 Outside the 8*COLS visible-pixel window all colour outputs and pixel SHALL be 0.
REQ-021 After textAddr for col COLS-1 is issued, fetch-active SHALL clear; no further textAddr changes until next lineStart; scanline SHALL increment at that point, wrapping 15->0 with row++, row wrapping ROWS-1 -> 0.
REQ-022 frameStart SHALL set row=0, scanline=0 and increment blink (mod 32).
REQ-023 frameStart and lineStart in the same cycle: frameStart applied first; that line fetches row 0 scanline 0.
REQ-024 lineStart while fetch-active SHALL abort the current line and restart at col 0 with unchanged row/scanline; partially fetched characters are discarded and visible window restarts.
REQ-025 textAddr arithmetic SHALL be 12-bit unsigned; maximum default value 2399.

Reset
REQ-026 nrst=0 at a posedge SHALL zero all counters, fetch-active, shifter, attribute registers, textAddr, fontAddr, all colour outputs and pixel, in the following cycle.
REQ-027 Reset asserted mid-line SHALL abort the line; no pixel output until a lineStart after release.

Verification
REQ-028 Reset, frameStart, lineStart with RAM all 0x1F41 ('A', fg white-intense... attr 0x1F) and font row 0x81 -> cycle 6 pixel=1 fgRed/Green/Blue/Intense=1, bgBlue=1; cycles 7-12 pixel=0; cycle 13 pixel=1; cycle 646 all outputs 0.
REQ-029 Address sequence: second visible line after frameStart -> textAddr 0,1..79 at cycles 1,9..633; fontAddr low nibble = 1; after 16 lines textAddr starts at 80.
REQ-030 Blink: attr 0x8F, font 0xFF, after 16 frameStarts (blink=16) -> pixel=0 all line; after 32 (blink=0) -> pixel=1.
REQ-031 frameStart and lineStart same cycle after row 29 scanline 15 -> textAddr=0, fontAddr nibble 0; row-wrap 29->0 without frameStart also checked.
REQ-032 lineStart re-pulsed at cycle 100 of a line -> textAddr returns to row base at cycle 101, pixels resume at cycle 106; reset at cycle 200 -> all outputs 0 at cycle 201 onward.
